// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types for the mux-select round-robin arbiter
package mux_arb_pkg;
    localparam int NREQ = 4;
    typedef logic [NREQ-1:0] req_vec_t;
    typedef logic [1:0] id_t;
    typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first unmasked request scanning upward from ptr, wrapping 3 to 0
module rr_priority_pick
    import mux_arb_pkg::*;
(
    input  req_vec_t req,
    input  id_t      ptr,
    input  req_vec_t mask,
    output logic     found,
    output id_t      idx,
    output req_vec_t onehot
);
    req_vec_t m;
    id_t      k;
    always_comb begin
        m     = req & ~mask;
        found = 1'b0;
        idx   = '0;
        k     = '0;
        // scan farthest offset first so the nearest hit overwrites it
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = ptr + id_t'(i);
            if (m[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
        onehot = found ? req_vec_t'(1) << idx : '0;
    end
endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// mux_sel_rr_arbiter: burst-capped round-robin arbiter driving registered one-hot mux selects
module mux_sel_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] last,
    output logic       sel_a,
    output logic       sel_b,
    output logic       sel_c,
    output logic       sel_d,
    output logic [1:0] grant_id,
    output logic       busy
);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    arb_state_t state, state_n;
    id_t        ptr, ptr_n, gid, gid_n, pick_ptr, pick_idx;
    req_vec_t   sel, sel_n, pick_mask, pick_oh;
    logic       pick_found, rel;
    logic [CW-1:0] cnt, cnt_n;
    // while granted, the pick starts after the owner and excludes it
    assign pick_ptr  = (state == GRANT) ? gid + 2'd1 : ptr;
    assign pick_mask = (state == GRANT) ? req_vec_t'(1) << gid : '0;
    assign rel = !req[gid] || last[gid] || (cnt == CW'(MAX_BURST - 1));
    rr_priority_pick u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .mask   (pick_mask),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        sel_n   = sel;
        gid_n   = gid;
        if (state == IDLE) begin
            if (pick_found) begin
                state_n = GRANT;
                sel_n   = pick_oh;
                gid_n   = pick_idx;
                cnt_n   = '0;
            end
        end else if (rel) begin
            ptr_n = gid + 2'd1;
            cnt_n = '0;
            if (pick_found) begin
                sel_n = pick_oh;
                gid_n = pick_idx;
            end else if (!req[gid]) begin
                state_n = IDLE;
                sel_n   = '0;
                gid_n   = '0;
            end
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            sel   <= '0;
            gid   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            sel   <= sel_n;
            gid   <= gid_n;
        end
    end
    assign {sel_d, sel_c, sel_b, sel_a} = sel;
    assign grant_id = gid;
    assign busy     = |sel;
endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// tb_mux_sel_rr_arbiter: directed vector table plus reset sequences for the arbiter
module tb_mux_sel_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] last = '0;
    logic       sel_a, sel_b, sel_c, sel_d, busy;
    logic [1:0] grant_id;
    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] last;
        logic [3:0] sel;
    } vec_t;
    vec_t v[$];

    mux_sel_rr_arbiter #(.MAX_BURST(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .last     (last),
        .sel_a    (sel_a),
        .sel_b    (sel_b),
        .sel_c    (sel_c),
        .sel_d    (sel_d),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input logic [3:0] s);
        return s[1] ? 2'd1 : s[2] ? 2'd2 : s[3] ? 2'd3 : 2'd0;
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] s);
        check({name, "_sel"}, {sel_d, sel_c, sel_b, sel_a}, s);
        check({name, "_gid"}, {2'b00, grant_id}, {2'b00, enc(s)});
        check({name, "_busy"}, {3'b000, busy}, {3'b000, |s});
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l);
        req  = r;
        last = l;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] l, input logic [3:0] s);
        v.push_back({r, l, s});
    endtask

    initial begin
        // rotation with last on every beat: a,b,c,d,a then idle (ptr -> 1)
        add(4'hF, 4'hF, 4'h1); add(4'hF, 4'hF, 4'h2); add(4'hF, 4'hF, 4'h4);
        add(4'hF, 4'hF, 4'h8); add(4'hF, 4'hF, 4'h1); add(4'h0, 4'h0, 4'h0);
        // lone requester c: 3 beats, last re-grants it, dropping req idles (ptr -> 3)
        add(4'h4, 4'h0, 4'h4); add(4'h4, 4'h0, 4'h4); add(4'h4, 4'h0, 4'h4);
        add(4'h4, 4'h4, 4'h4); add(4'h0, 4'h0, 4'h0);
        // burst cap of 8 cycles each; b's last is ignored while a owns
        for (int i = 0; i < 8; i++) add(4'h3, 4'h2, 4'h1);
        for (int i = 0; i < 8; i++) add(4'h3, 4'h0, 4'h2);
        add(4'h3, 4'h0, 4'h1); add(4'h0, 4'h0, 4'h0);
        // owner b drops, d takes over back-to-back, then ptr 0 picks a first
        add(4'hA, 4'h0, 4'h2); add(4'hA, 4'h8, 4'h2); add(4'h8, 4'h0, 4'h8);
        add(4'h8, 4'h8, 4'h8); add(4'h0, 4'h0, 4'h0); add(4'hF, 4'h0, 4'h1);
        add(4'h0, 4'h0, 4'h0);
        // a alone with last every beat stays granted continuously
        for (int i = 0; i < 10; i++) add(4'h1, 4'h1, 4'h1);
        add(4'h0, 4'h0, 4'h0);

        #1;
        chk_all("reset", 4'h0);
        @(negedge clk) rst_n = 1'b1;
        step(4'hF, 4'hF);
        step(4'hF, 4'hF);
        step(4'hF, 4'hF);
        chk_all("pre_rst_c", 4'h4);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 4'h0);
        @(negedge clk) rst_n = 1'b1;
        step(4'hF, 4'h0);
        chk_all("first_after_rst", 4'h1);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        chk_all("reset2", 4'h0);

        foreach (v[i]) begin
            step(v[i].req, v[i].last);
            chk_all($sformatf("vec%0d", i), v[i].sel);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
